// File: rtl/pixel_frame_loader.sv
// -----------------------------------------------------------------------------
// pixel_frame_loader
//
// Purpose:
//   Accepts a stream of 8-bit grayscale pixels from the input pins. Each pixel
//   is qualified by a strobe that is asynchronous to clk. Every pixel is
//   binarized against THRESH and packed row-major into an IMG_W x IMG_H bit
//   image. A complete image is offered to the classifier with a valid/ack
//   handshake.
//
// Ports:
//   clk          in   clock
//   rst          in   synchronous reset, active high
//   pix_data     in   [7:0]      grayscale pixel byte, stable around the strobe
//   pix_stb      in   pixel strobe, asynchronous level, one rising edge = one pixel
//   frame_sof    in   start-of-frame strobe, asynchronous level
//   frame_valid  out  complete frame held in frame_bits
//   frame_ack    in   classifier consumed the frame (single-cycle, clk domain)
//   frame_bits   out  [NPIX-1:0] packed binary image, pixel 0 at bit 0
//   pix_count    out  [CW-1:0]   pixels accepted in the current frame
//   ovf_err      out  sticky: a pixel arrived while the frame was full
//   checksum     out  [7:0]      XOR of accepted raw pixel bytes
//
// Build option:
//   PIXEL_CHECKSUM_EN - when defined, checksum accumulates the XOR of the
//   accepted pixel bytes. When undefined, checksum is tied to 8'h00 and no
//   flops are built for it.
// -----------------------------------------------------------------------------
module pixel_frame_loader #(
    parameter int  IMG_W  = 8,
    parameter int  IMG_H  = 8,
    parameter int  THRESH = 128,
    localparam int NPIX   = IMG_W * IMG_H,
    localparam int CW     = $clog2(NPIX + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      pix_data,
    input  logic            pix_stb,
    input  logic            frame_sof,
    output logic            frame_valid,
    input  logic            frame_ack,
    output logic [NPIX-1:0] frame_bits,
    output logic [CW-1:0]   pix_count,
    output logic            ovf_err,
    output logic [7:0]      checksum
);

    typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

    localparam logic [7:0] THR = 8'(THRESH);

    state_t          state_q, state_d;
    // [0],[1]: two-flop synchronizer; [2]: delayed copy used for edge detection
    logic [2:0]      stb_sync_q, sof_sync_q;
    // Edge events are registered, so an event is seen 3 cycles after the pin edge
    logic            pix_ev_q, sof_ev_q;
    logic            frame_valid_q, frame_valid_d;
    logic [NPIX-1:0] bits_q, bits_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic            clear_frame, accept_pix;
    logic            pix_bit;

    assign pix_bit = (pix_data >= THR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            stb_sync_q    <= '0;
            sof_sync_q    <= '0;
            pix_ev_q      <= 1'b0;
            sof_ev_q      <= 1'b0;
            frame_valid_q <= 1'b0;
            bits_q        <= '0;
            cnt_q         <= '0;
            ovf_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            stb_sync_q    <= {stb_sync_q[1:0], pix_stb};
            sof_sync_q    <= {sof_sync_q[1:0], frame_sof};
            pix_ev_q      <= stb_sync_q[1] & ~stb_sync_q[2];
            sof_ev_q      <= sof_sync_q[1] & ~sof_sync_q[2];
            frame_valid_q <= frame_valid_d;
            bits_q        <= bits_d;
            cnt_q         <= cnt_d;
            ovf_q         <= ovf_d;
        end
    end

    // Control: decides the state and whether this cycle clears or accepts.
    always_comb begin
        state_d       = state_q;
        frame_valid_d = 1'b0;
        ovf_d         = ovf_q;
        clear_frame   = 1'b0;
        accept_pix    = 1'b0;
        case (state_q)
            IDLE: begin
                if (sof_ev_q) begin
                    clear_frame = 1'b1;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                // sof has priority: a simultaneous pixel is dropped
                if (sof_ev_q) begin
                    clear_frame = 1'b1;
                end else if (pix_ev_q) begin
                    accept_pix = 1'b1;
                    if (cnt_q == CW'(NPIX - 1)) begin
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                // Valid follows FULL by one cycle and drops the cycle after ack
                frame_valid_d = ~frame_ack;
                if (pix_ev_q) begin
                    ovf_d = 1'b1;
                end
                if (frame_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pixel counter: the count is zeroed when a frame is cleared or acknowledged.
    // The image bits are kept until the next sof.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_frame || (state_q == FULL && frame_ack)) begin
            cnt_d = '0;
        end else if (accept_pix) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // One write-enable per image bit avoids a variable-index write into bits_q
    generate
        for (genvar gi = 0; gi < NPIX; gi++) begin : g_bit
            always_comb begin
                bits_d[gi] = bits_q[gi];
                if (clear_frame) begin
                    bits_d[gi] = 1'b0;
                end else if (accept_pix && cnt_q == CW'(gi)) begin
                    bits_d[gi] = pix_bit;
                end
            end
        end
    endgenerate

`ifdef PIXEL_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (clear_frame) begin
            csum_d = 8'h00;
        end else if (accept_pix) begin
            csum_d = csum_q ^ pix_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            csum_q <= 8'h00;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = 8'h00;
`endif

    assign frame_valid = frame_valid_q;
    assign frame_bits  = bits_q;
    assign pix_count   = cnt_q;
    assign ovf_err     = ovf_q;

endmodule

// File: tb/tb_pixel_frame_loader.sv
// -----------------------------------------------------------------------------
// tb_pixel_frame_loader
//
// Self-checking bench for pixel_frame_loader (8x8, THRESH=128). A behavioural
// frame model tracks what the loader should hold after each pin transaction.
// Directed sequences cover latency, the threshold, overflow, restart and
// checksum cases. A randomized phase follows.
// -----------------------------------------------------------------------------
module tb_pixel_frame_loader;

    localparam int NPIX = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  pix_data;
    logic        pix_stb;
    logic        frame_sof;
    logic        frame_valid;
    logic        frame_ack;
    logic [63:0] frame_bits;
    logic [6:0]  pix_count;
    logic        ovf_err;
    logic [7:0]  checksum;

    always #5 clk = ~clk;

    pixel_frame_loader #(
        .IMG_W  (8),
        .IMG_H  (8),
        .THRESH (128)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_data    (pix_data),
        .pix_stb     (pix_stb),
        .frame_sof   (frame_sof),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .frame_bits  (frame_bits),
        .pix_count   (pix_count),
        .ovf_err     (ovf_err),
        .checksum    (checksum)
    );

    // ---------------- reference model (frame-level view) ----------------
    bit          m_loading;
    bit          m_full;
    bit          m_ovf;
    logic [63:0] m_bits;
    int          m_count;
    logic [7:0]  m_csum;

    int n_cmp = 0;
    int n_bad = 0;
    int n_txn = 0;

    function automatic void model_rst();
        m_loading = 0; m_full = 0; m_ovf = 0;
        m_bits = '0; m_count = 0; m_csum = 8'h00;
    endfunction

    // Effect of one pin transaction that raised pixel and/or sof strobes together
    function automatic void model_event(bit p, bit s, logic [7:0] b);
        if (m_full) begin
            if (p) m_ovf = 1;
        end else if (s) begin
            m_bits = '0; m_count = 0; m_csum = 8'h00; m_loading = 1;
        end else if (p && m_loading) begin
            m_bits[m_count] = (b >= 8'd128);
            m_csum = m_csum ^ b;
            m_count++;
            if (m_count == NPIX) begin
                m_full = 1; m_loading = 0;
            end
        end
    endfunction

    function automatic void model_ack();
        if (m_full) begin
            m_full = 0; m_count = 0;
        end
    endfunction

    function automatic logic [7:0] exp_csum();
`ifdef PIXEL_CHECKSUM_EN
        return m_csum;
`else
        return 8'h00;
`endif
    endfunction

    // ---------------- checking ----------------
    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string op);
        n_txn++;
        $display("[txn %0d] %s valid=%0b count=%0d ovf=%0b csum=%02h bits=%016h",
                 n_txn, op, frame_valid, pix_count, ovf_err, checksum, frame_bits);
        cmp({op, ".valid"}, 64'(frame_valid), 64'(m_full));
        cmp({op, ".count"}, 64'(pix_count), 64'(m_count));
        cmp({op, ".ovf"},   64'(ovf_err), 64'(m_ovf));
        cmp({op, ".bits"},  frame_bits, m_bits);
        cmp({op, ".csum"},  64'(checksum), 64'(exp_csum()));
    endtask

    // ---------------- stimulus ----------------
    task automatic send(input bit p, input bit s, input logic [7:0] b);
        @(posedge clk); #1;
        pix_data = b; pix_stb = p; frame_sof = s;
        repeat (6) @(posedge clk);
        #1;
        pix_stb = 1'b0; frame_sof = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        model_event(p, s, b);
    endtask

    task automatic do_ack();
        @(posedge clk); #1 frame_ack = 1'b1;
        @(posedge clk); #1 frame_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_ack();
    endtask

    task automatic do_rst();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_rst();
    endtask

    typedef struct packed {
        logic [7:0] pix;
        logic       exp_bit;
    } vec_t;

    vec_t        vecs[8];
    logic [63:0] saved_bits;
    int          first_cnt;
    int          first_val;
    int          r;

    initial begin
        // Table: first pixels of a frame and the bit each must produce
        vecs[0] = '{pix: 8'd127, exp_bit: 1'b0};
        vecs[1] = '{pix: 8'd128, exp_bit: 1'b1};
        vecs[2] = '{pix: 8'd129, exp_bit: 1'b1};
        vecs[3] = '{pix: 8'd0,   exp_bit: 1'b0};
        vecs[4] = '{pix: 8'd255, exp_bit: 1'b1};
        vecs[5] = '{pix: 8'd100, exp_bit: 1'b0};
        vecs[6] = '{pix: 8'd200, exp_bit: 1'b1};
        vecs[7] = '{pix: 8'd1,   exp_bit: 1'b0};

        rst = 1'b1; pix_data = 8'h00; pix_stb = 1'b0; frame_sof = 1'b0; frame_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_rst();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");

        // Alternating frame; the last pixel is timed edge by edge
        send(0, 1, 8'h00);
        check_all("sof");
        for (int i = 0; i < NPIX - 1; i++) send(1, 0, (i % 2 == 0) ? 8'hFF : 8'h00);
        check_all("alt63");
        first_cnt = -1; first_val = -1;
        @(posedge clk); #1;
        pix_data = 8'h00; pix_stb = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (first_cnt < 0 && pix_count == 7'd64) first_cnt = k;
            if (first_val < 0 && frame_valid) first_val = k;
        end
        pix_stb = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        model_event(1, 0, 8'h00);
        cmp("lat_count", 64'(first_cnt), 64'd4);
        cmp("lat_valid", 64'(first_val), 64'd5);
        cmp("alt_bits", frame_bits, 64'h5555_5555_5555_5555);
        cmp("alt_count", 64'(pix_count), 64'd64);
        check_all("alt_full");
        do_ack();
        check_all("ack");

        // Threshold table, then random fill to full
        send(0, 1, 8'h00);
        for (int i = 0; i < 8; i++) begin
            send(1, 0, vecs[i].pix);
            cmp("thr_bit", 64'(frame_bits[i]), 64'(vecs[i].exp_bit));
            cmp("thr_count", 64'(pix_count), 64'(i + 1));
            check_all("thr_pix");
        end
        cmp("thr_low3", 64'(frame_bits[2:0]), 64'b110);
        for (int i = 8; i < NPIX; i++) send(1, 0, 8'($urandom_range(0, 255)));
        check_all("rand_fill");
        saved_bits = m_bits;
        send(1, 0, 8'hFF);
        send(1, 0, 8'h00);
        cmp("ovf_set", 64'(ovf_err), 64'd1);
        cmp("ovf_bits", frame_bits, saved_bits);
        check_all("overflow");
        send(0, 1, 8'h00);
        check_all("sof_in_full");
        do_ack();
        cmp("ovf_after_ack", 64'(ovf_err), 64'd1);
        check_all("ack_ovf");
        do_rst();
        cmp("ovf_after_rst", 64'(ovf_err), 64'd0);
        check_all("rst_ovf");

        // Restart after 20 pixels
        send(0, 1, 8'h00);
        for (int i = 0; i < 20; i++) send(1, 0, 8'($urandom_range(0, 255)));
        check_all("partial20");
        send(0, 1, 8'h00);
        for (int i = 0; i < NPIX; i++) send(1, 0, 8'hC8);
        cmp("restart_bits", frame_bits, 64'hFFFF_FFFF_FFFF_FFFF);
        cmp("restart_count", 64'(pix_count), 64'd64);
        check_all("restart_full");
        do_ack();
        check_all("ack2");

        // Pixels and ack in IDLE
        for (int i = 0; i < 3; i++) send(1, 0, 8'hFF);
        cmp("idle_count", 64'(pix_count), 64'd0);
        cmp("idle_valid", 64'(frame_valid), 64'd0);
        cmp("idle_ovf", 64'(ovf_err), 64'd0);
        check_all("idle_pix");
        do_ack();
        check_all("idle_ack");

        // sof and pixel together: sof wins
        send(0, 1, 8'h00);
        for (int i = 0; i < 5; i++) send(1, 0, 8'hF0);
        send(1, 1, 8'hFF);
        cmp("both_count", 64'(pix_count), 64'd0);
        check_all("sof_and_pix");

        // Reset mid-frame
        for (int i = 0; i < 10; i++) send(1, 0, 8'($urandom_range(0, 255)));
        do_rst();
        cmp("midrst_bits", frame_bits, 64'd0);
        check_all("mid_rst");

        // Checksum patterns
        send(0, 1, 8'h00);
        for (int i = 0; i < NPIX; i++) send(1, 0, 8'(1 << (i % 8)));
        cmp("csum_walk", 64'(checksum), 64'h00);
        check_all("csum_walk");
        do_ack();
        send(0, 1, 8'h00);
        send(1, 0, 8'h5A);
        for (int i = 1; i < NPIX; i++) send(1, 0, 8'h00);
`ifdef PIXEL_CHECKSUM_EN
        cmp("csum_5a", 64'(checksum), 64'h5A);
`else
        cmp("csum_5a", 64'(checksum), 64'h00);
`endif
        check_all("csum_5a");
        do_ack();
        check_all("ack3");

        // Randomized operations
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 199);
            if (r < 180) begin
                send(1, 0, 8'($urandom_range(0, 255)));
                check_all("r_pix");
            end else if (r < 186) begin
                send(0, 1, 8'h00);
                check_all("r_sof");
            end else if (r < 196) begin
                do_ack();
                check_all("r_ack");
            end else if (r < 199) begin
                send(1, 1, 8'($urandom_range(0, 255)));
                check_all("r_both");
            end else begin
                do_rst();
                check_all("r_rst");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
